cursor_blink: RTL and testbench



---
 rtl/cursor_blink_pkg.sv | 21 ++
 rtl/cursor_blink_if.sv | 20 ++
 rtl/cursor_blink.sv | 77 +++++++
 tb/tb_cursor_blink.sv | 124 ++++++++++++
 4 files changed

// File: rtl/cursor_blink_pkg.sv
// Shared constants, phase encoding and counter-width helper for the cursor blink generator.
// Optional feature macro: CURSOR_TOGGLE_PULSE_EN (adds the toggle pulse output).
package cursor_pkg;

    localparam int PIX_CLK_HZ         = 25000000;
    localparam int DEFAULT_ON_CYCLES  = PIX_CLK_HZ / 2;
    localparam int DEFAULT_OFF_CYCLES = PIX_CLK_HZ / 2;

    // Encoding chosen so the phase flop is the flash_on level itself.
    typedef enum logic {
        PH_HIDDEN  = 1'b0,
        PH_VISIBLE = 1'b1
    } phase_t;

    function automatic int cnt_width(input int on_cycles, input int off_cycles);
        int longest;
        longest = (on_cycles > off_cycles) ? on_cycles : off_cycles;
        return $clog2(longest + 1);
    endfunction

endpackage

// File: rtl/cursor_blink_if.sv
// Control/status bundle between the keyboard/console logic and the cursor blink generator.
// Optional feature macro: CURSOR_TOGGLE_PULSE_EN (adds toggle).
interface cursor_blink_if;

    logic en;
    logic restart;
    logic flash_on;
`ifdef CURSOR_TOGGLE_PULSE_EN
    logic toggle;
`endif

`ifdef CURSOR_TOGGLE_PULSE_EN
    modport master (output en, output restart, input flash_on, input toggle);
    modport slave  (input en, input restart, output flash_on, output toggle);
`else
    modport master (output en, output restart, input flash_on);
    modport slave  (input en, input restart, output flash_on);
`endif

endinterface

// File: rtl/cursor_blink.sv
// Free-running cursor blink generator: hidden for OFF_CYCLES, visible for ON_CYCLES, repeating.
// Optional feature macro: CURSOR_TOGGLE_PULSE_EN (one-cycle pulse whenever flash_on changes).
module cursor_blink
    import cursor_pkg::*;
#(
    parameter int ON_CYCLES  = DEFAULT_ON_CYCLES,
    parameter int OFF_CYCLES = DEFAULT_OFF_CYCLES
) (
    input  logic          clk,
    input  logic          rst,
    cursor_blink_if.slave bus
);

    localparam int CNT_W = cnt_width(ON_CYCLES, OFF_CYCLES);
    localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(OFF_CYCLES - 1);

    phase_t           phase_q, phase_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= PH_HIDDEN;
            cnt_q   <= '0;
        end else begin
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        phase_d = phase_q;
        cnt_d   = cnt_q + 1'b1;
        if (!bus.en) begin
            phase_d = PH_HIDDEN;
            cnt_d   = '0;
        end else if (bus.restart) begin
            // Restart re-arms a full visible phase even if already visible.
            phase_d = PH_VISIBLE;
            cnt_d   = '0;
        end else begin
            case (phase_q)
                PH_HIDDEN: begin
                    if (cnt_q == OFF_LAST) begin
                        phase_d = PH_VISIBLE;
                        cnt_d   = '0;
                    end
                end
                PH_VISIBLE: begin
                    if (cnt_q == ON_LAST) begin
                        phase_d = PH_HIDDEN;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    phase_d = PH_HIDDEN;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign bus.flash_on = (phase_q == PH_VISIBLE);

`ifdef CURSOR_TOGGLE_PULSE_EN
    logic toggle_q;

    // Registered alongside the phase so it is high during the first cycle of the new level.
    always_ff @(posedge clk) begin
        if (rst) toggle_q <= 1'b0;
        else     toggle_q <= (phase_d != phase_q);
    end

    assign bus.toggle = toggle_q;
`endif

endmodule

// File: tb/tb_cursor_blink.sv
// Self-checking bench: two instances (ON=4/OFF=3 and ON=1/OFF=1) against a period-position model.
module tb_cursor_blink;

    localparam int ON_A  = 4;
    localparam int OFF_A = 3;
    localparam int ON_B  = 1;
    localparam int OFF_B = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int checks = 0;
    int errors = 0;

    // Model: position inside one blink period; the cursor is visible when pos >= OFF.
    int  pos_a = 0, pos_b = 0;
    logic prev_a = 1'b0, prev_b = 1'b0;

    cursor_blink_if if_a ();
    cursor_blink_if if_b ();

    cursor_blink #(.ON_CYCLES(ON_A), .OFF_CYCLES(OFF_A)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (if_a)
    );

    cursor_blink #(.ON_CYCLES(ON_B), .OFF_CYCLES(OFF_B)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (if_b)
    );

    always #5 clk = ~clk;

    function automatic int next_pos(input int pos, input logic r, input logic e,
                                    input logic rs, input int on_c, input int off_c);
        if (r)       return 0;
        else if (!e) return 0;
        else if (rs) return off_c;
        else         return (pos + 1) % (on_c + off_c);
    endfunction

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0b expected=%0b (check %0d)", tag, obs, exp, checks);
        end
    endtask

    // One clock: apply inputs, advance model at the edge, check 1 time unit later.
    task automatic cyc(input logic r, input logic ea, input logic ra,
                       input logic eb, input logic rb, input string tag);
        logic exp_a, exp_b;
        rst          = r;
        if_a.en      = ea;
        if_a.restart = ra;
        if_b.en      = eb;
        if_b.restart = rb;
        @(posedge clk);
        pos_a = next_pos(pos_a, r, ea, ra, ON_A, OFF_A);
        pos_b = next_pos(pos_b, r, eb, rb, ON_B, OFF_B);
        exp_a = (pos_a >= OFF_A);
        exp_b = (pos_b >= OFF_B);
        #1;
        check_bit({tag, "_a"}, if_a.flash_on, exp_a);
        check_bit({tag, "_b"}, if_b.flash_on, exp_b);
`ifdef CURSOR_TOGGLE_PULSE_EN
        check_bit({tag, "_tog_a"}, if_a.toggle, r ? 1'b0 : (exp_a != prev_a));
        check_bit({tag, "_tog_b"}, if_b.toggle, r ? 1'b0 : (exp_b != prev_b));
`endif
        prev_a = exp_a;
        prev_b = exp_b;
    endtask

    initial begin
        if_a.en = 1'b0; if_a.restart = 1'b0;
        if_b.en = 1'b0; if_b.restart = 1'b0;
        #2;

        // Reset for two cycles, then enable and run five full periods.
        cyc(1, 1, 0, 1, 0, "reset");
        cyc(1, 1, 0, 1, 0, "reset");
        for (int i = 0; i < 5 * (ON_A + OFF_A); i++) cyc(0, 1, 0, 1, 0, "run");

        // Run into the visible phase to cnt=2, then restart.
        for (int i = 0; i < OFF_A + 2; i++) cyc(0, 1, 0, 1, 0, "pre_restart");
        cyc(0, 1, 1, 1, 1, "restart");
        for (int i = 0; i < ON_A + OFF_A + 2; i++) cyc(0, 1, 0, 1, 0, "post_restart");

        // Held restart keeps the cursor solid on.
        for (int i = 0; i < 10; i++) cyc(0, 1, 1, 1, 1, "held_restart");

        // Drop enable while visible, hold, then re-enable.
        cyc(0, 0, 0, 0, 0, "en_drop");
        for (int i = 0; i < 6; i++) cyc(0, 0, 1, 0, 1, "en_low");
        for (int i = 0; i < 2 * (ON_A + OFF_A); i++) cyc(0, 1, 0, 1, 0, "reenable");

        // Reset with en and restart both asserted while visible.
        while (pos_a < OFF_A) cyc(0, 1, 0, 1, 0, "to_visible");
        cyc(1, 1, 1, 1, 1, "rst_prio");
        for (int i = 0; i < ON_A + OFF_A; i++) cyc(0, 1, 0, 1, 0, "after_rst");

        // Randomized traffic: enable mostly on, restart and reset occasional.
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 49) == 0),
                ($urandom_range(0, 9) != 0), ($urandom_range(0, 11) == 0),
                ($urandom_range(0, 9) != 0), ($urandom_range(0, 11) == 0),
                "random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
